// File: rtl/hazard_ctrl_unit_if.sv
// Datapath <-> hazard controller bundle: pipeline specifiers and enables in,
// stall/flush/forward controls out. The controller side uses the slave modport.
interface hazard_ctrl_unit_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] RsD, RtD, RsE, RtE;
  logic [REG_W-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD, PCSrcD;
  logic             MdStartE, MdDone;
  logic             StallF, StallD, StallE;
  logic             FlushD, FlushE;
  logic             ForwardAD, ForwardBD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MdTimeoutErr;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdStartE, MdDone,
    input  StallF, StallD, StallE, FlushD, FlushE,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdTimeoutErr
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdStartE, MdDone,
    output StallF, StallD, StallE, FlushD, FlushE,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdTimeoutErr
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage F/D/E/M/W pipeline: forwarding
// selects, load-use and branch-data stalls, multi-cycle redirect flush, mul/div stall FSM.
module hazard_ctrl_unit #(
  parameter int REG_W           = 5,
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT      = 64
) (
  input logic                clk,
  input logic                rst_n,
  hazard_ctrl_unit_if.slave  hz
);
  localparam int TO_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(0);

  typedef enum logic [1:0] {IDLE, REDIRECT, MD_WAIT} state_e;

  state_e          state;
  logic [2:0]      flushCnt;
  logic [TO_W-1:0] mdCnt;
  logic            mdErr;

  // Destination register 0 never creates a dependency.
  logic destE, destM, destW;
  assign destE = hz.WriteRegE != ZERO_REG;
  assign destM = hz.WriteRegM != ZERO_REG;
  assign destW = hz.WriteRegW != ZERO_REG;

  logic fwdMA, fwdWA, fwdMB, fwdWB;
  assign fwdMA = hz.RegWriteM && destM && (hz.RsE == hz.WriteRegM);
  assign fwdWA = hz.RegWriteW && destW && (hz.RsE == hz.WriteRegW);
  assign fwdMB = hz.RegWriteM && destM && (hz.RtE == hz.WriteRegM);
  assign fwdWB = hz.RegWriteW && destW && (hz.RtE == hz.WriteRegW);

  assign hz.ForwardAE = fwdMA ? 2'b10 : (fwdWA ? 2'b01 : 2'b00);
  assign hz.ForwardBE = fwdMB ? 2'b10 : (fwdWB ? 2'b01 : 2'b00);
  assign hz.ForwardAD = hz.RegWriteM && destM && (hz.RsD == hz.WriteRegM);
  assign hz.ForwardBD = hz.RegWriteM && destM && (hz.RtD == hz.WriteRegM);

  logic srcHitE, srcHitM, lwStall, brStall, hzStall;
  assign srcHitE = destE && ((hz.RsD == hz.WriteRegE) || (hz.RtD == hz.WriteRegE));
  assign srcHitM = destM && ((hz.RsD == hz.WriteRegM) || (hz.RtD == hz.WriteRegM));
  assign lwStall = hz.MemtoRegE && srcHitE;
  assign brStall = hz.BranchD && ((hz.RegWriteE && srcHitE) || (hz.MemtoRegM && srcHitM));
  assign hzStall = lwStall || brStall;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      flushCnt <= '0;
      mdCnt    <= '0;
      mdErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.MdStartE) begin
            // Any remaining redirect flush cycles are dropped when an MD op starts.
            state <= MD_WAIT;
            mdCnt <= '0;
          end else if (hz.PCSrcD && !hzStall && (BR_FLUSH_CYCLES > 1)) begin
            state    <= REDIRECT;
            flushCnt <= 3'(BR_FLUSH_CYCLES - 1);
          end
        end
        REDIRECT: begin
          flushCnt <= flushCnt - 3'd1;
          if (flushCnt == 3'd1) state <= IDLE;
        end
        MD_WAIT: begin
          if (hz.MdDone) begin
            state <= IDLE;
            mdCnt <= '0;
          end else if (mdCnt == TO_W'(MD_TIMEOUT - 1)) begin
            mdErr <= 1'b1;
            state <= IDLE;
            mdCnt <= '0;
          end else begin
            mdCnt <= mdCnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic stallF, stallD, stallE, flushD, flushE;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    case (state)
      IDLE: begin
        stallF = hzStall;
        stallD = hzStall;
        flushE = hzStall;
        // A redirect behind a stall is deferred and re-evaluated next cycle.
        flushD = hz.PCSrcD && !hzStall;
      end
      REDIRECT: flushD = 1'b1;
      MD_WAIT: begin
        // FlushE stays low so the instruction held in E is not lost.
        stallF = !hz.MdDone;
        stallD = !hz.MdDone;
        stallE = !hz.MdDone;
      end
      default: ;
    endcase
  end

  // NOTE: controls are gated by rst_n so they read 0 during reset, not only after the flops clear.
  assign hz.StallF       = stallF && rst_n;
  assign hz.StallD       = stallD && rst_n;
  assign hz.StallE       = stallE && rst_n;
  assign hz.FlushD       = flushD && rst_n;
  assign hz.FlushE       = flushE && rst_n;
  assign hz.MdTimeoutErr = mdErr;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: instance A (3 flush cycles, timeout 64) and instance B (1 flush cycle, timeout 8).
module tb_hazard_ctrl_unit;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_unit_if #(.REG_W(5)) ifA ();
  hazard_ctrl_unit_if #(.REG_W(5)) ifB ();

  hazard_ctrl_unit #(.REG_W(5), .BR_FLUSH_CYCLES(3), .MD_TIMEOUT(64)) dutA (
    .clk(clk), .rst_n(rst_n), .hz(ifA.slave)
  );
  hazard_ctrl_unit #(.REG_W(5), .BR_FLUSH_CYCLES(1), .MD_TIMEOUT(8)) dutB (
    .clk(clk), .rst_n(rst_n), .hz(ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // {StallF, StallD, StallE, FlushD, FlushE}
  function automatic logic [4:0] ctlA();
    return {ifA.StallF, ifA.StallD, ifA.StallE, ifA.FlushD, ifA.FlushE};
  endfunction
  function automatic logic [4:0] ctlB();
    return {ifB.StallF, ifB.StallD, ifB.StallE, ifB.FlushD, ifB.FlushE};
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic clearA();
    ifA.RsD = '0; ifA.RtD = '0; ifA.RsE = '0; ifA.RtE = '0;
    ifA.WriteRegE = '0; ifA.WriteRegM = '0; ifA.WriteRegW = '0;
    ifA.RegWriteE = 0; ifA.RegWriteM = 0; ifA.RegWriteW = 0;
    ifA.MemtoRegE = 0; ifA.MemtoRegM = 0; ifA.BranchD = 0; ifA.PCSrcD = 0;
    ifA.MdStartE = 0; ifA.MdDone = 0;
  endtask

  task automatic clearB();
    ifB.RsD = '0; ifB.RtD = '0; ifB.RsE = '0; ifB.RtE = '0;
    ifB.WriteRegE = '0; ifB.WriteRegM = '0; ifB.WriteRegW = '0;
    ifB.RegWriteE = 0; ifB.RegWriteM = 0; ifB.RegWriteW = 0;
    ifB.MemtoRegE = 0; ifB.MemtoRegM = 0; ifB.BranchD = 0; ifB.PCSrcD = 0;
    ifB.MdStartE = 0; ifB.MdDone = 0;
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clearA();
    clearB();
    // Load-use pattern applied during reset: outputs must stay gated off.
    ifA.MemtoRegE = 1; ifA.WriteRegE = 5'd8; ifA.RsD = 5'd8;
    #1;
    check("reset_ctl_gated", 8'(ctlA()), 8'b00000);
    check("reset_err", 8'(ifA.MdTimeoutErr), 8'd0);
    #11;
    rst_n = 1'b1;
    #1;
    check("loaduse_stall", 8'(ctlA()), 8'b11001);

    tick();
    ifA.WriteRegE = 5'd0; ifA.RsD = 5'd0;
    #1 check("loaduse_r0", 8'(ctlA()), 8'b00000);

    // Forwarding priority and register-0 rule.
    tick(); clearA();
    ifA.RsE = 5'd5; ifA.RtE = 5'd5; ifA.WriteRegM = 5'd5; ifA.WriteRegW = 5'd5;
    ifA.RegWriteM = 1; ifA.RegWriteW = 1;
    #1 check("fwdAE_M", 8'(ifA.ForwardAE), 8'd2);
    check("fwdBE_M", 8'(ifA.ForwardBE), 8'd2);
    ifA.RegWriteM = 0;
    #1 check("fwdAE_W", 8'(ifA.ForwardAE), 8'd1);
    check("fwdBE_W", 8'(ifA.ForwardBE), 8'd1);
    ifA.RsE = 5'd0; ifA.WriteRegM = 5'd0; ifA.WriteRegW = 5'd0; ifA.RegWriteM = 1;
    #1 check("fwdAE_r0", 8'(ifA.ForwardAE), 8'd0);
    ifA.RsD = 5'd7; ifA.RtD = 5'd7; ifA.WriteRegM = 5'd7;
    #1 check("fwdAD", 8'(ifA.ForwardAD), 8'd1);
    check("fwdBD", 8'(ifA.ForwardBD), 8'd1);
    ifA.RegWriteM = 0;
    #1 check("fwdAD_off", 8'(ifA.ForwardAD), 8'd0);

    // Branch data hazard via E-stage write, then via M-stage load.
    tick(); clearA();
    ifA.BranchD = 1; ifA.RtD = 5'd3; ifA.RegWriteE = 1; ifA.WriteRegE = 5'd3; ifA.PCSrcD = 1;
    #1 check("brstall_E", 8'(ctlA()), 8'b11001);
    ifA.RegWriteE = 0; ifA.RsD = 5'd9; ifA.MemtoRegM = 1; ifA.WriteRegM = 5'd9;
    #1 check("brstall_M", 8'(ctlA()), 8'b11001);

    // Hazard gone: redirect taken, FlushD exactly three cycles.
    tick(); clearA();
    ifA.PCSrcD = 1;
    #1 check("redir_c0", 8'(ctlA()), 8'b00010);
    tick(); ifA.PCSrcD = 0;
    #1 check("redir_c1", 8'(ctlA()), 8'b00010);
    tick(); ifA.PCSrcD = 1;
    #1 check("redir_c2", 8'(ctlA()), 8'b00010);
    tick(); ifA.PCSrcD = 0;
    #1 check("redir_c3_done", 8'(ctlA()), 8'b00000);

    // MD op: ten stalled cycles, stalls drop combinationally with MdDone.
    tick(); ifA.MdStartE = 1;
    #1 check("md_start", 8'(ctlA()), 8'b00000);
    tick(); ifA.MdStartE = 0;
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("md_wait_%0d", i), 8'(ctlA()), 8'b11100);
      if (i < 9) tick();
    end
    ifA.MdDone = 1;
    #1 check("md_done", 8'(ctlA()), 8'b00000);
    tick(); ifA.MdDone = 0;
    #1 check("md_idle", 8'(ctlA()), 8'b00000);

    // MdStartE with PCSrcD: flush now, extra flush cycles dropped, redirect in MD_WAIT deferred.
    ifA.MdStartE = 1; ifA.PCSrcD = 1;
    #1 check("md_redir_c0", 8'(ctlA()), 8'b00010);
    tick(); ifA.MdStartE = 0;
    #1 check("md_redir_c1", 8'(ctlA()), 8'b11100);
    tick(); ifA.MdDone = 1; ifA.PCSrcD = 0;
    #1 check("md_redir_done", 8'(ctlA()), 8'b00000);
    tick(); clearA();
    #1 check("md_redir_idle", 8'(ctlA()), 8'b00000);

    // Instance B: single-cycle redirect flush.
    ifB.PCSrcD = 1;
    #1 check("B_redir_c0", 8'(ctlB()), 8'b00010);
    tick(); ifB.PCSrcD = 0;
    #1 check("B_redir_c1", 8'(ctlB()), 8'b00000);

    // Instance B: timeout after 8 stalled cycles, flag sticky.
    ifB.MdStartE = 1;
    tick(); ifB.MdStartE = 0;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("B_to_wait_%0d", i), 8'(ctlB()), 8'b11100);
      check($sformatf("B_to_err_%0d", i), 8'(ifB.MdTimeoutErr), 8'd0);
      tick();
    end
    #1 check("B_to_idle", 8'(ctlB()), 8'b00000);
    check("B_to_err_set", 8'(ifB.MdTimeoutErr), 8'd1);
    tick();
    #1 check("B_to_err_sticky", 8'(ifB.MdTimeoutErr), 8'd1);

    // Restart an MD op, then assert reset between clock edges.
    ifB.MdStartE = 1;
    tick(); ifB.MdStartE = 0;
    #1 check("B_restall", 8'(ctlB()), 8'b11100);
    rst_n = 1'b0;
    #1 check("B_async_rst_ctl", 8'(ctlB()), 8'b00000);
    check("B_async_rst_err", 8'(ifB.MdTimeoutErr), 8'd0);
    tick();
    rst_n = 1'b1;
    #1 check("B_post_rst_idle", 8'(ctlB()), 8'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Generates E-stage and D-stage (branch-compare) forwarding selects, load-use and branch-data stalls, and redirect flushes over a configurable number of wrong-path cycles.
- Adds a multi-cycle-unit (mul/div) stall FSM with timeout detection.
- Sits beside the datapath and drives all stall/flush enables of the pipeline registers.

Parameters:
- REG_W, 5, register-specifier width.
- BR_FLUSH_CYCLES, 1, number of consecutive cycles FlushD is asserted per taken redirect (1..7).
- MD_TIMEOUT, 64, max cycles in MD_WAIT before MdTimeoutErr sets (2..1023).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RsD, RtD  in  REG_W  D-stage source specifiers.
- RsE, RtE  in  REG_W  E-stage source specifiers.
- WriteRegE, WriteRegM, WriteRegW  in  REG_W  destination specifiers per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables.
- MemtoRegE, MemtoRegM  in  1  stage holds a load.
- BranchD  in  1  D-stage instruction is a branch or jump-register (compares in D).
- PCSrcD  in  1  redirect taken in D.
- MdStartE  in  1  multi-cycle op issued from E this cycle.
- MdDone  in  1  multi-cycle result ready.
- StallF, StallD, StallE  out  1  hold the respective pipeline register.
- FlushD, FlushE  out  1  clear the respective pipeline register.
- ForwardAD, ForwardBD  out  1  D compare operand from M-stage ALU result.
- ForwardAE, ForwardBE  out  2  E operand select: 10=M, 01=W, 00=register file.
- MdTimeoutErr  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, flush counter=0, timeout counter=0, MdTimeoutErr=0. All stall/flush outputs read 0 while rst_n is low. Forwarding outputs stay purely combinational.
- Register 0 is never a hazard. Any match term requires the compared destination != 0.
- ForwardAE: 10 if RsE==WriteRegM&RegWriteM; else 01 if RsE==WriteRegW&RegWriteW; else 00. M has priority over W. ForwardBE is the same using RtE.
- ForwardAD = RsD==WriteRegM&RegWriteM. ForwardBD uses RtD.
- lwstall = MemtoRegE & (RsD==WriteRegE | RtD==WriteRegE).
- brstall = BranchD & ((RegWriteE & (RsD|RtD)==WriteRegE) | (MemtoRegM & (RsD|RtD)==WriteRegM)).
- FSM states:
  - IDLE:
    - MdStartE=1: next state MD_WAIT.
    - else PCSrcD & !lwstall & !brstall: FlushD=1 this cycle. If BR_FLUSH_CYCLES>1, load counter=BR_FLUSH_CYCLES-1 and go to REDIRECT.
  - REDIRECT: FlushD=1, counter decrements each cycle, return to IDLE when the counter reaches 1→0. PCSrcD is ignored in this state.
  - MD_WAIT: StallF=StallD=StallE=1 and FlushE=0. Timeout counter increments each cycle.
    - MdDone=1: stalls deassert combinationally in the same cycle, next state IDLE, counter cleared.
    - Counter reaching MD_TIMEOUT: MdTimeoutErr=1 (sticky until reset) and return to IDLE.
- Stall/flush composition:
  - In IDLE, lwstall|brstall gives StallF=StallD=FlushE=1.
  - MD_WAIT overrides load/branch stalls: FlushE is held 0 so E is not lost.
  - A redirect while stalled is deferred. The stall wins and PCSrcD is re-evaluated next cycle.
  - MdStartE and PCSrcD in the same IDLE cycle: FlushD=1 this cycle and the FSM enters MD_WAIT. The remaining redirect flush cycles are dropped; BR_FLUSH_CYCLES>1 is documented unsupported with MD ops.
- Reset mid-REDIRECT or mid-MD_WAIT aborts immediately to IDLE. The MdTimeoutErr flag clears.
- No added latency: all outputs are combinational from current inputs plus registered state.

Test Plan:
- Load-use: MemtoRegE=1, WriteRegE=8, RsD=8 → StallF=StallD=FlushE=1 for one cycle. With WriteRegE=0, RsD=0 → all 0.
- Forward priority: RsE=5, WriteRegM=5, WriteRegW=5, both RegWrite=1 → ForwardAE=10. Drop RegWriteM → 01. RsE=0 → 00.
- Branch data: BranchD=1, RtD=3, RegWriteE=1, WriteRegE=3 → stall, and PCSrcD=1 in the same cycle yields FlushD=0. Next cycle with no match → FlushD=1.
- Redirect, BR_FLUSH_CYCLES=3: PCSrcD pulse → FlushD high exactly 3 cycles. A second PCSrcD in cycle 2 has no extension.
- MD op: MdStartE=1, MdDone after 10 cycles → StallF/D/E high 10 cycles, low in the MdDone cycle, FlushE=0 throughout.
- Timeout: MD_TIMEOUT=8, MdDone never → MdTimeoutErr=1 after 8 stalled cycles, FSM IDLE. rst_n low mid-stall → all stall/flush outputs and the flag go 0 asynchronously.
